// File: rtl/config_chain_loader_pkg.sv
// Shared types and sizing for the configuration chain loader.
package config_chain_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_WORD,
    SHIFT,
    DONE
  } state_e;

  localparam int DEFAULT_WORD_WIDTH   = 32;
  localparam int DEFAULT_CHAIN_LENGTH = 36;
  localparam int NUM_WORDS =
    (DEFAULT_CHAIN_LENGTH + DEFAULT_WORD_WIDTH - 1) / DEFAULT_WORD_WIDTH;

endpackage

// File: rtl/config_chain_loader_serializer.sv
// Parallel-in serial-out word register with a per-word bit counter.
module config_word_serializer #(
  parameter int WORD_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(WORD_WIDTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_i,
  input  logic                  shift_i,
  input  logic [WORD_WIDTH-1:0] word_i,
  input  logic [CNT_WIDTH-1:0]  nbits_i,
  output logic                  bit_o,
  output logic                  last_o,
  output logic [CNT_WIDTH-1:0]  pos_o
);

  logic [WORD_WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]  len_q, len_d;

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    if (load_i) begin
      shreg_d = word_i;
      cnt_d   = '0;
      len_d   = nbits_i;
    end else if (shift_i) begin
      shreg_d = shreg_q >> 1;
      cnt_d   = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  assign bit_o  = shreg_q[0];
  assign pos_o  = cnt_q;
  assign last_o = (cnt_q == len_q - CNT_WIDTH'(1));

endmodule

// File: rtl/config_chain_loader.sv
// Feeds configuration words serially into the tile config chain and
// captures the old chain contents emerging from the tail as readback words.
module config_chain_loader
  import config_chain_loader_pkg::*;
#(
  parameter int WORD_WIDTH   = 32,
  parameter int CHAIN_LENGTH = 36,
  parameter int COUNT_WIDTH  = $clog2(CHAIN_LENGTH + 1)
) (
  input  logic                  config_clock,
  input  logic                  config_nreset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  chain_data,
  output logic                  chain_enable,
  input  logic                  chain_tail,
  output logic [WORD_WIDTH-1:0] rb_data,
  output logic                  rb_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted
);

  localparam int PosWidth = $clog2(WORD_WIDTH + 1);

  state_e                state_q, state_d;
  logic [COUNT_WIDTH-1:0] bitCnt_q, bitCnt_d;
  logic [WORD_WIDTH-1:0]  capture_q, capture_d;
  logic [WORD_WIDTH-1:0]  rbData_q, rbData_d;
  logic                   rbValid_q, rbValid_d;
  logic                   aborted_q, aborted_d;

  logic                   serLoad, serShift, serBit, serLast;
  logic [PosWidth-1:0]    serPos;
  logic [PosWidth-1:0]    wordBits;
  logic [COUNT_WIDTH-1:0] remaining;
  logic                   finalBit;
  logic [WORD_WIDTH-1:0]  sample;

  config_word_serializer #(
    .WORD_WIDTH(WORD_WIDTH),
    .CNT_WIDTH (PosWidth)
  ) u_serializer (
    .clk_i  (config_clock),
    .rst_ni (config_nreset),
    .load_i (serLoad),
    .shift_i(serShift),
    .word_i (word_data),
    .nbits_i(wordBits),
    .bit_o  (serBit),
    .last_o (serLast),
    .pos_o  (serPos)
  );

  // The final word carries only the bits still missing from the chain.
  assign remaining = COUNT_WIDTH'(CHAIN_LENGTH) - bitCnt_q;
  assign wordBits  = (int'(remaining) < WORD_WIDTH) ? PosWidth'(remaining)
                                                     : PosWidth'(WORD_WIDTH);
  assign finalBit  = (bitCnt_q == COUNT_WIDTH'(CHAIN_LENGTH - 1));
  assign sample    = capture_q | (WORD_WIDTH'(chain_tail) << serPos);

  always_comb begin
    state_d   = state_q;
    bitCnt_d  = bitCnt_q;
    capture_d = capture_q;
    rbData_d  = rbData_q;
    rbValid_d = 1'b0;
    aborted_d = 1'b0;
    serLoad   = 1'b0;
    serShift  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = WAIT_WORD;
          bitCnt_d  = '0;
          capture_d = '0;
        end
      end
      WAIT_WORD: begin
        if (abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
          capture_d = '0;
        end else if (word_valid) begin
          serLoad = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
          capture_d = '0;
        end else begin
          serShift = 1'b1;
          bitCnt_d = bitCnt_q + COUNT_WIDTH'(1);
          // A full word boundary and the last chain bit both flush the capture.
          if (serLast || finalBit) begin
            rbData_d  = sample;
            rbValid_d = 1'b1;
            capture_d = '0;
            state_d   = finalBit ? DONE : WAIT_WORD;
          end else begin
            capture_d = sample;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge config_clock or negedge config_nreset) begin
    if (!config_nreset) begin
      state_q   <= IDLE;
      bitCnt_q  <= '0;
      capture_q <= '0;
      rbData_q  <= '0;
      rbValid_q <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bitCnt_q  <= bitCnt_d;
      capture_q <= capture_d;
      rbData_q  <= rbData_d;
      rbValid_q <= rbValid_d;
      aborted_q <= aborted_d;
    end
  end

  assign word_ready   = (state_q == WAIT_WORD);
  assign busy         = (state_q == WAIT_WORD) || (state_q == SHIFT);
  assign chain_enable = (state_q == SHIFT);
  assign chain_data   = (state_q == SHIFT) && serBit;
  assign done         = (state_q == DONE);
  assign rb_data      = rbData_q;
  assign rb_valid     = rbValid_q;
  assign aborted      = aborted_q;

endmodule

// File: tb/tb_config_chain_loader.sv
// Bench for config_chain_loader with a behavioural 36-bit chain on the serial side.
module tb_config_chain_loader;

  logic        config_clock;
  logic        config_nreset;
  logic        start;
  logic        abort;
  logic [31:0] word_data;
  logic        word_valid;
  logic        word_ready;
  logic        chain_data;
  logic        chain_enable;
  logic        chain_tail;
  logic [31:0] rb_data;
  logic        rb_valid;
  logic        busy;
  logic        done;
  logic        aborted;

  config_chain_loader dut (
    .config_clock (config_clock),
    .config_nreset(config_nreset),
    .start        (start),
    .abort        (abort),
    .word_data    (word_data),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .chain_data   (chain_data),
    .chain_enable (chain_enable),
    .chain_tail   (chain_tail),
    .rb_data      (rb_data),
    .rb_valid     (rb_valid),
    .busy         (busy),
    .done         (done),
    .aborted      (aborted)
  );

  initial config_clock = 1'b0;
  always #5 config_clock = ~config_clock;

  // Chain model: new bits enter at bit 0, bit 35 is the tail.
  logic [35:0] chain;
  logic        preloadReq;
  logic [35:0] preloadVal;
  always @(posedge config_clock) begin
    if (preloadReq) chain <= preloadVal;
    else if (chain_enable) chain <= {chain[34:0], chain_data};
  end
  assign chain_tail = chain[35];

  typedef struct {
    logic [31:0] w0;
    logic [31:0] w1;
    logic [35:0] preload;
    logic [35:0] expChain;
    logic [31:0] expRb0;
    logic [31:0] expRb1;
    int          stall;
    bit          startPulse;
  } vec_t;

  vec_t vecs[3];

  int testsRun;
  int testsFailed;
  int enCount;
  int doneCount;
  int rbCount;
  int busyAtDoneBad;
  int stallBad;
  logic [31:0] rbWords[2];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge config_clock);
    #1;
    if (chain_enable) enCount++;
    if (done) begin
      doneCount++;
      if (busy) busyAtDoneBad++;
    end
    if (rb_valid) begin
      if (rbCount < 2) rbWords[rbCount] = rb_data;
      rbCount++;
    end
  endtask

  task automatic clearCounters();
    enCount = 0;
    doneCount = 0;
    rbCount = 0;
    busyAtDoneBad = 0;
    stallBad = 0;
    rbWords[0] = '0;
    rbWords[1] = '0;
  endtask

  task automatic preloadChain(input logic [35:0] v);
    preloadVal = v;
    preloadReq = 1'b1;
    @(posedge config_clock);
    #1;
    preloadReq = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    int wordIdx;
    int stallLeft;
    bit stalled;
    logic [31:0] words[2];
    words[0] = v.w0;
    words[1] = v.w1;
    wordIdx = 0;
    stallLeft = v.stall;
    preloadChain(v.preload);
    clearCounters();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 200 && doneCount == 0; cyc++) begin
      stalled = 1'b0;
      start = (v.startPulse && chain_enable && enCount == 5);
      if (word_ready && wordIdx < 2) begin
        if (stallLeft > 0) begin
          word_valid = 1'b0;
          stallLeft--;
          stalled = 1'b1;
        end else begin
          word_valid = 1'b1;
          word_data = words[wordIdx];
          wordIdx++;
        end
      end else begin
        word_valid = 1'b0;
      end
      tick();
      if (stalled && (!word_ready || chain_enable)) stallBad++;
    end
    start = 1'b0;
    word_valid = 1'b0;
  endtask

  task automatic checkLoad(input string tag, input vec_t v);
    for (int i = 0; i < 3; i++) tick();
    checkOutput({tag, " enable count"}, 64'(enCount), 64'd36);
    checkOutput({tag, " done count"}, 64'(doneCount), 64'd1);
    checkOutput({tag, " busy at done"}, 64'(busyAtDoneBad), 64'd0);
    checkOutput({tag, " rb_valid count"}, 64'(rbCount), 64'd2);
    checkOutput({tag, " rb word0"}, 64'(rbWords[0]), 64'(v.expRb0));
    checkOutput({tag, " rb word1"}, 64'(rbWords[1]), 64'(v.expRb1));
    checkOutput({tag, " chain"}, 64'(chain), 64'(v.expChain));
    checkOutput({tag, " stall"}, 64'(stallBad), 64'd0);
    checkOutput({tag, " idle after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    testsRun = 0;
    testsFailed = 0;
    clearCounters();
    preloadReq = 1'b0;
    preloadVal = '0;
    config_nreset = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    word_data = '0;
    word_valid = 1'b0;

    vecs[0] = '{w0: 32'hA5A5_A5A5, w1: 32'h0000_000C, preload: 36'h0_0000_0000,
                expChain: 36'hA_5A5A_5A53, expRb0: 32'h0000_0000, expRb1: 32'h0000_0000,
                stall: 0, startPulse: 1'b0};
    vecs[1] = '{w0: 32'h0000_0001, w1: 32'hFFFF_FFF0, preload: 36'h9_1234_5678,
                expChain: 36'h8_0000_0000, expRb0: 32'hE6A2_C489, expRb1: 32'h0000_0001,
                stall: 5, startPulse: 1'b0};
    vecs[2] = '{w0: 32'hFFFF_FFFF, w1: 32'h0000_0005, preload: 36'hF_0000_000F,
                expChain: 36'hF_FFFF_FFFA, expRb0: 32'h0000_000F, expRb1: 32'h0000_000F,
                stall: 0, startPulse: 1'b1};

    #3;
    checkOutput("reset outputs",
                64'({busy, done, aborted, rb_valid, word_ready, chain_enable, chain_data}), 64'd0);
    checkOutput("reset rb_data", 64'(rb_data), 64'd0);
    @(negedge config_clock);
    @(negedge config_clock);
    config_nreset = 1'b1;

    for (int i = 0; i < 3; i++) begin
      applyStimulus(vecs[i]);
      checkLoad($sformatf("vec%0d", i), vecs[i]);
    end

    // Abort in the 10th shift cycle of the first word.
    preloadChain(36'h0_0000_0000);
    clearCounters();
    start = 1'b1;
    tick();
    start = 1'b0;
    word_valid = 1'b1;
    word_data = 32'hFFFF_FFFF;
    tick();
    word_valid = 1'b0;
    for (int cyc = 0; cyc < 50 && enCount < 10; cyc++) tick();
    checkOutput("abort reached shift 10", 64'(enCount), 64'd10);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abort pulse", 64'(aborted), 64'd1);
    checkOutput("abort enable low", 64'(chain_enable), 64'd0);
    checkOutput("abort idle", 64'({busy, word_ready}), 64'd0);
    tick();
    checkOutput("abort pulse single", 64'(aborted), 64'd0);
    tick();
    checkOutput("abort no done", 64'(doneCount), 64'd0);
    checkOutput("abort no rb_valid", 64'(rbCount), 64'd0);
    checkOutput("abort enable total", 64'(enCount), 64'd10);
    applyStimulus(vecs[0]);
    checkLoad("post-abort", vecs[0]);

    // Asynchronous reset between clock edges mid-shift.
    preloadChain(36'h0_0000_0000);
    clearCounters();
    start = 1'b1;
    tick();
    start = 1'b0;
    word_valid = 1'b1;
    word_data = 32'h1234_5678;
    tick();
    word_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    #3;
    config_nreset = 1'b0;
    #1;
    checkOutput("async reset outputs",
                64'({busy, done, aborted, rb_valid, word_ready, chain_enable, chain_data}), 64'd0);
    checkOutput("async reset rb_data", 64'(rb_data), 64'd0);
    @(negedge config_clock);
    config_nreset = 1'b1;
    applyStimulus(vecs[1]);
    checkLoad("post-reset", vecs[1]);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
